// File: rtl/n64_vbus_capture_pkg.sv
// Shared constants, state encoding and vdata packing for the N64 video-bus capture front end.
package n64adv_vbus_pkg;

  localparam int COLOR_W = 7;
  localparam int SYNC_W  = 4;
  localparam int VDATA_W = SYNC_W + 3 * COLOR_W;

  // Field positions inside vdata: {nVSYNC,nCLAMP,nHSYNC,nCSYNC, R, G, B}
  localparam int B_LSB  = 0;
  localparam int G_LSB  = COLOR_W;
  localparam int R_LSB  = 2 * COLOR_W;
  localparam int SY_LSB = 3 * COLOR_W;

  localparam int NVSYNC_BIT = 3;
  localparam int NHSYNC_BIT = 1;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } vbusState_e;

  function automatic logic [VDATA_W-1:0] packVdata(
    input logic [SYNC_W-1:0]  nib,
    input logic [COLOR_W-1:0] red,
    input logic [COLOR_W-1:0] green,
    input logic [COLOR_W-1:0] blue
  );
    logic [VDATA_W-1:0] v;
    v = '0;
    v[SY_LSB +: SYNC_W] = nib;
    v[R_LSB  +: COLOR_W] = red;
    v[G_LSB  +: COLOR_W] = green;
    v[B_LSB  +: COLOR_W] = blue;
    return v;
  endfunction

endpackage

// File: rtl/n64_vbus_capture_if.sv
// Multiplexed N64 video bus: the group strobe plus the shared sync/colour data lines.
interface n64_vbus_capture_if
  import n64adv_vbus_pkg::*;
;
  logic               nVDSYNC;
  logic [COLOR_W-1:0] VD_i;

  modport master (output nVDSYNC, output VD_i);
  modport slave  (input  nVDSYNC, input  VD_i);
endinterface

// File: rtl/n64_vbus_capture_phase_tracker.sv
// Follows the 4-phase nVDSYNC group rhythm, counts clean groups to lock and flags alignment loss.
module n64_vbus_phase_tracker
  import n64adv_vbus_pkg::*;
#(
  parameter int LOCK_GROUPS = 4
) (
  input  logic       VCLK,
  input  logic       VRST,
  input  logic       nVDSYNC_i,
  output logic [1:0] ph_o,
  output logic       groupDone_o,
  output logic       locked_o,
  output logic       phase_err_o
);

  localparam int CNT_W = $clog2(LOCK_GROUPS + 1);
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(LOCK_GROUPS - 1);

  vbusState_e       state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic [CNT_W-1:0] lockCnt_q, lockCnt_d;
  logic             phaseErr_q, phaseErr_d;
  logic             malformed;

  always_ff @(posedge VCLK) begin
    if (VRST) begin
      state_q    <= HUNT;
      ph_q       <= 2'd0;
      lockCnt_q  <= '0;
      phaseErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      lockCnt_q  <= lockCnt_d;
      phaseErr_q <= phaseErr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    lockCnt_d   = lockCnt_q;
    phaseErr_d  = 1'b0;
    // Sync low anywhere but phase 0 is early; sync high at phase 0 is late.
    malformed   = nVDSYNC_i ? (ph_q == 2'd0) : (ph_q != 2'd0);
    groupDone_o = nVDSYNC_i && (ph_q == 2'd3);

    if (!nVDSYNC_i) begin
      ph_d = 2'd1;
    end else if (ph_q != 2'd0) begin
      ph_d = ph_q + 2'd1;
    end

    case (state_q)
      HUNT: begin
        if (malformed) begin
          lockCnt_d = '0;
        end else if (groupDone_o) begin
          if (lockCnt_q == LAST_GROUP) begin
            state_d   = LOCKED;
            lockCnt_d = '0;
          end else begin
            lockCnt_d = lockCnt_q + CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (malformed) begin
          phaseErr_d = 1'b1;
          state_d    = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign ph_o        = ph_q;
  assign locked_o    = (state_q == LOCKED);
  assign phase_err_o = phaseErr_q;

endmodule

// File: rtl/n64_vbus_capture.sv
// N64 video-bus capture: assembles {sync,R,G,B} per group and derives line/frame info from sync edges.
module n64_vbus_capture
  import n64adv_vbus_pkg::*;
#(
  parameter int LINE_CNT_W  = 10,
  parameter int LOCK_GROUPS = 4,
  parameter int PAL_THRESH  = 290
) (
  input  logic                  VCLK,
  input  logic                  VRST,
  n64_vbus_capture_if.slave     vbus,
  output logic [VDATA_W-1:0]    vdata_o,
  output logic                  vdata_valid_o,
  output logic                  locked_o,
  output logic                  phase_err_o,
  output logic                  pal_mode_o,
  output logic                  n64_480i_o,
  output logic [LINE_CNT_W-1:0] line_cnt_o
);

  localparam logic [LINE_CNT_W-1:0] PAL_LIMIT = LINE_CNT_W'(PAL_THRESH);

  logic [1:0]            ph;
  logic                  groupDone, accept, vsFall, hsFall;
  logic [SYNC_W-1:0]     syncNib_q, syncNib_d, prevNib_q, prevNib_d;
  logic [COLOR_W-1:0]    red_q, red_d, green_q, green_d;
  logic [VDATA_W-1:0]    vdata_q, vdata_d;
  logic                  valid_q, valid_d, seeded_q, seeded_d;
  logic                  pal_q, pal_d, i480_q, i480_d, lastOdd_q, lastOdd_d;
  logic [LINE_CNT_W-1:0] lineCnt_q, lineCnt_d;

  n64_vbus_phase_tracker #(
    .LOCK_GROUPS(LOCK_GROUPS)
  ) u_tracker (
    .VCLK       (VCLK),
    .VRST       (VRST),
    .nVDSYNC_i  (vbus.nVDSYNC),
    .ph_o       (ph),
    .groupDone_o(groupDone),
    .locked_o   (locked_o),
    .phase_err_o(phase_err_o)
  );

  always_ff @(posedge VCLK) begin
    if (VRST) begin
      syncNib_q <= '0;
      prevNib_q <= '0;
      red_q     <= '0;
      green_q   <= '0;
      vdata_q   <= '0;
      valid_q   <= 1'b0;
      seeded_q  <= 1'b0;
      pal_q     <= 1'b0;
      i480_q    <= 1'b0;
      lastOdd_q <= 1'b0;
      lineCnt_q <= '0;
    end else begin
      syncNib_q <= syncNib_d;
      prevNib_q <= prevNib_d;
      red_q     <= red_d;
      green_q   <= green_d;
      vdata_q   <= vdata_d;
      valid_q   <= valid_d;
      seeded_q  <= seeded_d;
      pal_q     <= pal_d;
      i480_q    <= i480_d;
      lastOdd_q <= lastOdd_d;
      lineCnt_q <= lineCnt_d;
    end
  end

  always_comb begin
    syncNib_d = syncNib_q;
    prevNib_d = prevNib_q;
    red_d     = red_q;
    green_d   = green_q;
    vdata_d   = vdata_q;
    valid_d   = 1'b0;
    seeded_d  = seeded_q;
    pal_d     = pal_q;
    i480_d    = i480_q;
    lastOdd_d = lastOdd_q;
    lineCnt_d = lineCnt_q;

    if (!vbus.nVDSYNC) begin
      syncNib_d = vbus.VD_i[SYNC_W-1:0];
    end else if (ph == 2'd1) begin
      red_d = vbus.VD_i;
    end else if (ph == 2'd2) begin
      green_d = vbus.VD_i;
    end

    accept = groupDone && locked_o;
    vsFall = prevNib_q[NVSYNC_BIT] && !syncNib_q[NVSYNC_BIT];
    hsFall = prevNib_q[NHSYNC_BIT] && !syncNib_q[NHSYNC_BIT];

    if (!locked_o) begin
      seeded_d = 1'b0;
    end

    // The first accepted nibble after lock has no trustworthy predecessor, so it only seeds.
    if (accept) begin
      vdata_d   = packVdata(syncNib_q, red_q, green_q, vbus.VD_i);
      valid_d   = 1'b1;
      prevNib_d = syncNib_q;
      seeded_d  = 1'b1;
      if (seeded_q) begin
        if (vsFall) begin
          pal_d     = (lineCnt_q > PAL_LIMIT);
          i480_d    = (lineCnt_q[0] != lastOdd_q);
          lastOdd_d = lineCnt_q[0];
          lineCnt_d = '0;
        end else if (hsFall && (lineCnt_q != '1)) begin
          lineCnt_d = lineCnt_q + LINE_CNT_W'(1);
        end
      end
    end
  end

  assign vdata_o       = vdata_q;
  assign vdata_valid_o = valid_q;
  assign pal_mode_o    = pal_q;
  assign n64_480i_o    = i480_q;
  assign line_cnt_o    = lineCnt_q;

endmodule

// File: tb/tb_n64_vbus_capture.sv
// Bench for n64_vbus_capture: table vectors for lock/error, frame sequences and random traffic vs a model.
module tb_n64_vbus_capture;

  logic        VCLK = 1'b0;
  logic        VRST = 1'b1;
  logic [24:0] vdata_o;
  logic        vdata_valid_o, locked_o, phase_err_o, pal_mode_o, n64_480i_o;
  logic [9:0]  line_cnt_o;

  int errors = 0;
  int checks = 0;

  n64_vbus_capture_if busIf ();

  n64_vbus_capture dut (
    .VCLK         (VCLK),
    .VRST         (VRST),
    .vbus         (busIf),
    .vdata_o      (vdata_o),
    .vdata_valid_o(vdata_valid_o),
    .locked_o     (locked_o),
    .phase_err_o  (phase_err_o),
    .pal_mode_o   (pal_mode_o),
    .n64_480i_o   (n64_480i_o),
    .line_cnt_o   (line_cnt_o)
  );

  always #5 VCLK = ~VCLK;

  // Behavioural model: position in group, clean-group streak, and frame bookkeeping as plain ints.
  int         mPos, mStreak, mLine, mFrame;
  bit         mLocked, mSeeded, mPal, mI480, mValid, mErr;
  logic [3:0] mNib, mPrevNib;
  logic [6:0] mR, mG;
  logic [24:0] mVdata;

  function automatic void modelReset();
    mPos = 0; mStreak = 0; mLine = 0; mFrame = 0;
    mLocked = 0; mSeeded = 0; mPal = 0; mI480 = 0; mValid = 0; mErr = 0;
    mNib = '0; mPrevNib = '0; mR = '0; mG = '0; mVdata = '0;
  endfunction

  function automatic void modelStep(input bit rst, input bit ns, input logic [6:0] vd);
    bit good, done, vsF, hsF;
    mValid = 0;
    mErr   = 0;
    if (rst) begin
      modelReset();
      return;
    end
    good = ((ns == 1'b0) == (mPos == 0));
    done = ns && (mPos == 3);
    if (!ns) mNib = vd[3:0];
    else if (mPos == 1) mR = vd;
    else if (mPos == 2) mG = vd;
    if (!good) begin
      if (mLocked) mErr = 1;
      mLocked = 0; mSeeded = 0; mStreak = 0;
    end else if (done) begin
      if (mLocked) begin
        mVdata = {mNib, mR, mG, vd};
        mValid = 1;
        if (mSeeded) begin
          vsF = mPrevNib[3] && !mNib[3];
          hsF = mPrevNib[1] && !mNib[1];
          if (vsF) begin
            mPal   = (mLine > 290);
            mI480  = ((mLine % 2) != (mFrame % 2));
            mFrame = mLine;
            mLine  = 0;
          end else if (hsF && mLine < 1023) begin
            mLine++;
          end
        end
        mSeeded  = 1;
        mPrevNib = mNib;
      end else begin
        mStreak++;
        if (mStreak == 4) begin
          mLocked = 1;
          mStreak = 0;
        end
      end
    end
    if (!ns) mPos = 1;
    else if (mPos != 0) mPos = (mPos + 1) % 4;
  endfunction

  task automatic applyStimulus(input bit rst, input bit ns, input logic [6:0] vd);
    VRST          = rst;
    busIf.nVDSYNC = ns;
    busIf.VD_i    = vd;
    @(posedge VCLK);
    #1;
    modelStep(rst, ns, vd);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name,
      {24'd0, vdata_o, vdata_valid_o, locked_o, phase_err_o, pal_mode_o, n64_480i_o, line_cnt_o},
      {24'd0, mVdata, mValid, mLocked, mErr, mPal, mI480, 10'(mLine)});
  endtask

  task automatic sendGroupChk(input logic [3:0] nib, input string name);
    applyStimulus(1'b0, 1'b0, {3'($urandom), nib}); checkModel(name);
    applyStimulus(1'b0, 1'b1, 7'($urandom));        checkModel(name);
    applyStimulus(1'b0, 1'b1, 7'($urandom));        checkModel(name);
    applyStimulus(1'b0, 1'b1, 7'($urandom));        checkModel(name);
  endtask

  task automatic sendLines(input int n);
    for (int i = 0; i < n; i++) begin
      sendGroupChk(4'hF, "line hi");
      sendGroupChk(4'hD, "line hsync");
    end
  endtask

  task automatic sendVsync();
    sendGroupChk(4'hF, "pre vsync");
    sendGroupChk(4'h7, "vsync");
  endtask

  task automatic checkFrame(input string name, input bit expPal, input bit expI, input logic [9:0] expLine);
    checkOutput({name, " pal"},  {63'd0, pal_mode_o}, {63'd0, expPal});
    checkOutput({name, " 480i"}, {63'd0, n64_480i_o}, {63'd0, expI});
    checkOutput({name, " line"}, {54'd0, line_cnt_o}, {54'd0, expLine});
  endtask

  typedef struct {
    bit          rst;
    bit          ns;
    logic [6:0]  vd;
    bit          expLocked;
    bit          expValid;
    bit          expErr;
    logic [24:0] expVdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(bit rst, bit ns, logic [6:0] vd, bit lk, bit vl, bit er, logic [24:0] vdat);
    vec_t v;
    v.rst = rst; v.ns = ns; v.vd = vd;
    v.expLocked = lk; v.expValid = vl; v.expErr = er; v.expVdata = vdat;
    vecs.push_back(v);
  endfunction

  function automatic void addGroup(logic [3:0] nib, logic [6:0] r, logic [6:0] g, logic [6:0] b,
                                   bit lkPre, bit lkPost, bit validB,
                                   logic [24:0] vdPre, logic [24:0] vdPost);
    addVec(0, 0, {3'b000, nib}, lkPre, 0, 0, vdPre);
    addVec(0, 1, r, lkPre, 0, 0, vdPre);
    addVec(0, 1, g, lkPre, 0, 0, vdPre);
    addVec(0, 1, b, lkPost, validB, 0, vdPost);
  endfunction

  initial begin
    logic [24:0] v1, v2;
    int  tbPos;
    bit  ns, rst;

    v1 = {4'hF, 7'h01, 7'h02, 7'h03};
    v2 = {4'hA, 7'h44, 7'h55, 7'h66};
    busIf.nVDSYNC = 1'b1;
    busIf.VD_i    = '0;
    modelReset();

    // Reset, four clean groups to lock, fifth group emits.
    addVec(1, 1, 7'h00, 0, 0, 0, 25'd0);
    for (int g = 0; g < 4; g++)
      addGroup(4'hF, 7'h01, 7'h02, 7'h03, 0, (g == 3), 0, 25'd0, 25'd0);
    addGroup(4'hF, 7'h01, 7'h02, 7'h03, 1, 1, 1, 25'd0, v1);
    // Early sync at phase 2 while locked.
    addVec(0, 0, 7'h0F, 1, 0, 0, v1);
    addVec(0, 1, 7'h01, 1, 0, 0, v1);
    addVec(0, 0, 7'h05, 0, 0, 1, v1);
    for (int i = 0; i < 4; i++) addVec(0, 1, 7'h00, 0, 0, 0, v1);
    for (int g = 0; g < 4; g++)
      addGroup(4'h5, 7'h11, 7'h22, 7'h33, 0, (g == 3), 0, v1, v1);
    addGroup(4'hA, 7'h44, 7'h55, 7'h66, 1, 1, 1, v1, v2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ns, vecs[i].vd);
      checkOutput($sformatf("vec%0d", i),
        {36'd0, vdata_o, locked_o, vdata_valid_o, phase_err_o},
        {36'd0, vecs[i].expVdata, vecs[i].expLocked, vecs[i].expValid, vecs[i].expErr});
    end

    // Frame sequences.
    sendVsync();
    checkFrame("first vsync", 0, 0, 10'd0);
    for (int k = 0; k < 3; k++) begin
      sendLines(263);
      checkOutput("lines before vsync", {54'd0, line_cnt_o}, {54'd0, 10'd263});
      sendVsync();
      checkFrame($sformatf("ntsc frame%0d", k), 0, (k == 0), 10'd0);
    end
    sendLines(313);
    sendVsync();
    checkFrame("pal frame", 1, 0, 10'd0);
    sendLines(262); sendVsync(); checkFrame("alt 262a", 0, 1, 10'd0);
    sendLines(263); sendVsync(); checkFrame("alt 263",  0, 1, 10'd0);
    sendLines(262); sendVsync(); checkFrame("alt 262b", 0, 1, 10'd0);

    // Both sync edges in one nibble: vsync wins, hsync not counted.
    sendLines(10);
    checkOutput("ten lines", {54'd0, line_cnt_o}, {54'd0, 10'd10});
    sendGroupChk(4'hF, "pre combo");
    sendGroupChk(4'h5, "combo");
    checkFrame("combo edge", 0, 0, 10'd0);

    sendLines(1030);
    checkOutput("line saturate", {54'd0, line_cnt_o}, {54'd0, 10'd1023});
    sendVsync();
    checkFrame("saturated frame", 1, 1, 10'd0);

    // Reset mid-group while locked.
    applyStimulus(0, 0, 7'h0F); checkModel("pre reset sync");
    applyStimulus(0, 1, 7'h12); checkModel("pre reset r");
    applyStimulus(1, 1, 7'h34);
    checkOutput("reset mid-group",
      {24'd0, vdata_o, vdata_valid_o, locked_o, phase_err_o, pal_mode_o, n64_480i_o, line_cnt_o}, 64'd0);

    // Random traffic with occasional phase glitches and resets.
    tbPos = 0;
    for (int c = 0; c < 3000; c++) begin
      ns  = (tbPos != 0);
      if ($urandom_range(0, 39) == 0) ns = ~ns;
      rst = ($urandom_range(0, 599) == 0);
      applyStimulus(rst, ns, 7'($urandom));
      checkModel("random");
      if (rst) tbPos = 0;
      else if (!ns) tbPos = 1;
      else tbPos = (tbPos + 1) % 4;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
